// File: rtl/pulse_transmitter_sequencer_pkg.sv
// Shared definitions for the pulse transmitter sequencer.
//   state_t        : sequencer FSM states (IDLE / LOAD / RUN)
//   SYM_DUR_LSB    : low bit of the duration field in a symbol word
//   sym_dur_msb()  : high bit of the duration field for a given timer width
//   sym_level_bit(): position of the line-level bit for a given timer width
package pulse_transmitter_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Symbol word layout: {level, duration[TIMER_WIDTH-1:0]}
    localparam int SYM_DUR_LSB = 0;

    function automatic int sym_dur_msb(input int timer_width);
        return SYM_DUR_LSB + timer_width - 1;
    endfunction

    function automatic int sym_level_bit(input int timer_width);
        return SYM_DUR_LSB + timer_width;
    endfunction

endpackage

// File: rtl/pulse_transmitter_sequencer_if.sv
// Control, configuration, symbol-memory and line signals of the sequencer.
//   master : the controller / symbol memory side (drives start, stop, cfg_*,
//            symbol_data; observes symbol_addr, line_out, busy, done)
//   slave  : the sequencer itself
interface pulse_transmitter_sequencer_if #(
    parameter int PRESCALER_WIDTH = 16,
    parameter int TIMER_WIDTH     = 8,
    parameter int ADDR_WIDTH      = 4
);
    logic                               start;
    logic                               stop;
    logic [$clog2(PRESCALER_WIDTH)-1:0] cfg_prescaler;
    logic [ADDR_WIDTH-1:0]              cfg_last_addr;
    logic [7:0]                         cfg_loop_count;
    logic                               cfg_idle_level;
    logic [ADDR_WIDTH-1:0]              symbol_addr;
    logic [TIMER_WIDTH:0]               symbol_data;
    logic                               line_out;
    logic                               busy;
    logic                               done;

    modport master (
        output start, stop, cfg_prescaler, cfg_last_addr, cfg_loop_count,
               cfg_idle_level, symbol_data,
        input  symbol_addr, line_out, busy, done
    );

    modport slave (
        input  start, stop, cfg_prescaler, cfg_last_addr, cfg_loop_count,
               cfg_idle_level, symbol_data,
        output symbol_addr, line_out, busy, done
    );
endinterface

// File: rtl/pulse_transmitter_countdown_timer.sv
// Symbol duration timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low clears the timer
//   prescaler  : exponent p, duration scaled by 2^p
//   duration   : symbol duration d
//   pulse      : registered one-cycle pulse, high in the cycle that starts
//                ((d+1)<<p) cycles after the first enabled cycle
// The sequencer samples pulse one edge later, so the end-to-end symbol
// period measured from en rising is ((d+1)<<p)+1 cycles.
module pulse_transmitter_countdown_timer #(
    parameter int PRESCALER_WIDTH = 16,
    parameter int TIMER_WIDTH     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler,
    input  logic [TIMER_WIDTH-1:0]             duration,
    output logic                               pulse
);
    // Wide enough for (2^TIMER_WIDTH) << (PRESCALER_WIDTH-1)
    localparam int CW = TIMER_WIDTH + PRESCALER_WIDTH;

    logic [CW-1:0] cnt;
    logic [CW-1:0] span;

    assign span = ({{PRESCALER_WIDTH{1'b0}}, duration} + CW'(1)) << prescaler;

    // cnt holds the number of enabled cycles already elapsed; the pulse
    // register is set when cnt reaches span-1 so it shows in cycle span.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            cnt   <= cnt + CW'(1);
            pulse <= (cnt == span - CW'(1));
        end
    end
endmodule

// File: rtl/pulse_transmitter_sequencer.sv
// Pulse transmitter sequencer.
// Plays a program of {level, duration} symbols from an external
// combinational symbol memory onto line_out, repeating the program
// cfg_loop_count extra times.
//   clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : start/stop requests, cfg_* (shadowed at start),
//                    symbol_addr/symbol_data memory port, line_out, busy, done
module pulse_transmitter_sequencer
    import pulse_transmitter_sequencer_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 16,
    parameter int TIMER_WIDTH     = 8,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                          clk,
    input  logic                          sys_rst_n,
    pulse_transmitter_sequencer_if.slave  bus
);
    localparam int PW            = $clog2(PRESCALER_WIDTH);
    localparam int SYM_LEVEL_BIT = sym_level_bit(TIMER_WIDTH);
    localparam int SYM_DUR_MSB   = sym_dur_msb(TIMER_WIDTH);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ADDR_WIDTH-1:0]  last_addr;
    logic [7:0]             loop_remaining;
    logic [PW-1:0]          prescaler;
    logic [TIMER_WIDTH-1:0] duration;
    logic                   line_q;
    logic                   done_q;
    logic                   timer_en;
    logic                   timer_pulse;

    pulse_transmitter_countdown_timer #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .TIMER_WIDTH     (TIMER_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .en        (timer_en),
        .prescaler (prescaler),
        .duration  (duration),
        .pulse     (timer_pulse)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            last_addr      <= '0;
            loop_remaining <= '0;
            prescaler      <= '0;
            duration       <= '0;
            line_q         <= 1'b0;
            done_q         <= 1'b0;
            timer_en       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                // Abort takes priority over everything, including start
                state    <= IDLE;
                addr     <= '0;
                timer_en <= 1'b0;
                line_q   <= bus.cfg_idle_level;
            end else begin
                case (state)
                    IDLE: begin
                        timer_en <= 1'b0;
                        line_q   <= bus.cfg_idle_level;
                        if (bus.start) begin
                            prescaler      <= bus.cfg_prescaler;
                            last_addr      <= bus.cfg_last_addr;
                            loop_remaining <= bus.cfg_loop_count;
                            addr           <= '0;
                            state          <= LOAD;
                        end
                    end
                    LOAD: begin
                        // Level goes straight to the line; duration feeds
                        // the timer, which first looks at it a cycle later.
                        duration <= bus.symbol_data[SYM_DUR_MSB:SYM_DUR_LSB];
                        line_q   <= bus.symbol_data[SYM_LEVEL_BIT];
                        timer_en <= 1'b1;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (timer_pulse) begin
                            timer_en <= 1'b0;
                            if (addr != last_addr) begin
                                addr  <= addr + 1'b1;
                                state <= LOAD;
                            end else if (loop_remaining != 8'd0) begin
                                loop_remaining <= loop_remaining - 8'd1;
                                addr           <= '0;
                                state          <= LOAD;
                            end else begin
                                // Line keeps the last level through this
                                // cycle; IDLE restores the idle level next.
                                addr   <= '0;
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.symbol_addr = addr;
    assign bus.line_out    = line_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
module tb_pulse_transmitter_sequencer;
    localparam int PRESCALER_WIDTH = 16;
    localparam int TIMER_WIDTH     = 8;
    localparam int ADDR_WIDTH      = 4;

    typedef struct {
        logic       line;
        logic       busy;
        logic       done;
        logic       ac;     // symbol_addr is defined for this cycle
        logic [3:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b1;
    logic [8:0] mem [0:15];

    exp_t exp_q[$];
    exp_t ce;
    int   nvec = 0;
    int   nmis = 0;
    int   done_cnt = 0;
    int   hi_cnt = 0;
    logic chk_en = 1'b0;
    int   n;

    always #5 clk = ~clk;

    pulse_transmitter_sequencer_if #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .TIMER_WIDTH     (TIMER_WIDTH),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) bus ();

    pulse_transmitter_sequencer #(
        .PRESCALER_WIDTH (PRESCALER_WIDTH),
        .TIMER_WIDTH     (TIMER_WIDTH),
        .ADDR_WIDTH      (ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    assign bus.symbol_data = mem[bus.symbol_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the expectation queue; with the
    // queue empty the block must be sitting idle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) begin
                ce = exp_q.pop_front();
                check("line", 32'(bus.line_out), 32'(ce.line));
                check("busy", 32'(bus.busy), 32'(ce.busy));
                check("done", 32'(bus.done), 32'(ce.done));
                if (ce.ac) check("addr", 32'(bus.symbol_addr), 32'(ce.addr));
            end else begin
                check("idle_line", 32'(bus.line_out), 32'(bus.cfg_idle_level));
                check("idle_busy", 32'(bus.busy), 32'd0);
                check("idle_done", 32'(bus.done), 32'd0);
                check("idle_timer_en", 32'(dut.timer_en), 32'd0);
            end
            if (bus.done) done_cnt++;
            if (bus.line_out) hi_cnt++;
        end
    end

    task automatic rand_cfg();
        bus.cfg_prescaler  = 4'($urandom_range(0, 15));
        bus.cfg_last_addr  = 4'($urandom_range(0, 15));
        bus.cfg_loop_count = 8'($urandom_range(0, 255));
    endtask

    task automatic set_idle(input logic v);
        chk_en = 1'b0;
        bus.cfg_idle_level = v;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
    endtask

    task automatic set_prog(input int p, input int last, input int loops);
        bus.cfg_prescaler  = 4'(p);
        bus.cfg_last_addr  = 4'(last);
        bus.cfg_loop_count = 8'(loops);
    endtask

    // Start a transmission and queue what the line must look like:
    // one LOAD cycle at the old level, then every symbol holds its level
    // for ((d+1)<<p)+2 cycles; the final cycle of the program is the done
    // cycle (busy already low).
    task automatic run_prog(input logic hold, input logic rnd, output int cnt);
        int   p, last, loops, t;
        logic idle, fin;
        exp_t e;
        p     = int'(bus.cfg_prescaler);
        last  = int'(bus.cfg_last_addr);
        loops = int'(bus.cfg_loop_count);
        idle  = bus.cfg_idle_level;
        cnt   = 0;
        done_cnt = 0;
        hi_cnt   = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 if (!hold) bus.start = 1'b0;
        e.line = idle; e.busy = 1'b1; e.done = 1'b0; e.ac = 1'b1; e.addr = 4'd0;
        exp_q.push_back(e); cnt++;
        for (int r = 0; r <= loops; r++) begin
            for (int i = 0; i <= last; i++) begin
                t = ((int'(mem[i][7:0]) + 1) << p) + 1;
                for (int c = 0; c <= t; c++) begin
                    fin    = (r == loops) && (i == last) && (c == t);
                    e.line = mem[i][8];
                    e.busy = !fin;
                    e.done = fin;
                    e.ac   = (c < t);
                    e.addr = 4'(i);
                    exp_q.push_back(e); cnt++;
                end
            end
        end
        if (hold) begin
            repeat (cnt - 1) begin
                @(posedge clk); #1 if (rnd) rand_cfg();
            end
            bus.start = 1'b0;
        end
        for (int k = 0; k < 5000 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1 if (rnd) rand_cfg();
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_req34();
        mem[0] = {1'b1, 8'd3};
        mem[1] = {1'b0, 8'd1};
        set_prog(0, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.cfg_idle_level = 1'b1;
        set_prog(0, 0, 0);
        #2 sys_rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", 32'(bus.line_out), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.symbol_addr), 32'd0);
        check("rst_timer_en", 32'(dut.timer_en), 32'd0);
        @(posedge clk); #3 sys_rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_line_idle", 32'(bus.line_out), 32'd1);
        chk_en = 1'b1;

        // Two-symbol program, no loop
        set_idle(1'b0);
        load_req34();
        run_prog(1'b0, 1'b0, n);
        check("req34_len", 32'(n), 32'd11);
        check("req34_high", 32'(hi_cnt), 32'd6);
        check("req34_done", 32'(done_cnt), 32'd1);

        // Single symbol, duration 0, prescaler 2
        mem[0] = {1'b1, 8'd0};
        set_prog(2, 0, 0);
        run_prog(1'b0, 1'b0, n);
        check("req35_len", 32'(n), 32'd7);
        check("req35_high", 32'(hi_cnt), 32'd6);
        check("req35_done", 32'(done_cnt), 32'd1);

        // Two-symbol program looped three times
        load_req34();
        bus.cfg_loop_count = 8'd2;
        run_prog(1'b0, 1'b0, n);
        check("req36_len", 32'(n), 32'd31);
        check("req36_high", 32'(hi_cnt), 32'd18);
        check("req36_done", 32'(done_cnt), 32'd1);

        // Stop two cycles into RUN of symbol 0
        set_idle(1'b1);
        mem[0] = {1'b0, 8'd3};
        mem[1] = {1'b1, 8'd1};
        set_prog(0, 1, 0);
        done_cnt = 0;
        begin
            exp_t e;
            @(posedge clk); #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            e.line = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.ac = 1'b1; e.addr = 4'd0;
            exp_q.push_back(e);
            e.line = 1'b0;
            exp_q.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1 bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 32'd0);
        check("stop_line", 32'(bus.line_out), 32'd1);
        check("stop_timer_en", 32'(dut.timer_en), 32'd0);
        repeat (10) @(posedge clk);
        #1 check("stop_no_done", 32'(done_cnt), 32'd0);

        // Reset in the middle of RUN
        done_cnt = 0;
        begin
            exp_t e;
            @(posedge clk); #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
            e.line = 1'b1; e.busy = 1'b1; e.done = 1'b0; e.ac = 1'b1; e.addr = 4'd0;
            exp_q.push_back(e);
            e.line = 1'b0;
            exp_q.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        chk_en = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        check("mrst_line", 32'(bus.line_out), 32'd0);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_done", 32'(bus.done), 32'd0);
        check("mrst_addr", 32'(bus.symbol_addr), 32'd0);
        check("mrst_timer_en", 32'(dut.timer_en), 32'd0);
        check("mrst_no_done", 32'(done_cnt), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 sys_rst_n = 1'b1;
        @(posedge clk); #1;
        check("mrst_rel_line", 32'(bus.line_out), 32'd1);
        chk_en = 1'b1;
        set_idle(1'b0);
        load_req34();
        run_prog(1'b0, 1'b0, n);
        check("restart_high", 32'(hi_cnt), 32'd6);
        check("restart_done", 32'(done_cnt), 32'd1);

        // start held high for the whole transmission
        load_req34();
        run_prog(1'b1, 1'b0, n);
        check("hold_high", 32'(hi_cnt), 32'd6);
        check("hold_done", 32'(done_cnt), 32'd1);

        // start and stop together while idle
        done_cnt = 0;
        @(posedge clk); #1 begin bus.start = 1'b1; bus.stop = 1'b1; end
        @(posedge clk); #1 begin bus.start = 1'b0; bus.stop = 1'b0; end
        check("ss_busy", 32'(bus.busy), 32'd0);
        repeat (5) @(posedge clk);
        #1 check("ss_no_done", 32'(done_cnt), 32'd0);

        // Randomized programs with cfg churn while busy
        for (int t = 0; t < 25; t++) begin
            set_idle(1'($urandom_range(0, 1)));
            for (int i = 0; i < 16; i++)
                mem[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 5))};
            set_prog(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)));
            run_prog(1'($urandom_range(0, 1)), 1'b1, n);
            check("rand_done", 32'(done_cnt), 32'd1);
            repeat (2) @(posedge clk);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
